vred_seq_ctrl: RTL

Sequencer for the pairwise reduction datapath (sum/min/max over two DATA_WIDTH operands). It accepts one reduction request (op, SEW, element count, initial scalar) and streams vl elements in over a valid/ready port. It folds each element into a running accumulator by issuing {element, accumulator} pairs to the datapath, then returns the scalar result on a valid/ready output. It sits between the vector issue logic and the reduction unit and owns all datapath control.

---
 rtl/vred_seq_ctrl_if.sv | 40 ++++
 rtl/vred_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vred_seq_ctrl_if.sv
// Request, element, datapath and result buses between the reduction sequencer and its neighbours.
// slave = sequencer side, master = issue logic / reduction unit / result consumer side.
interface vred_seq_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 9,
  parameter int SEW_WIDTH   = 2,
  parameter int VL_WIDTH    = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [OPSEL_WIDTH-1:0]  req_opsel;
  logic [SEW_WIDTH-1:0]    req_sew;
  logic [VL_WIDTH-1:0]     req_vl;
  logic [DATA_WIDTH-1:0]   req_init;
  logic                    elem_valid;
  logic                    elem_ready;
  logic [DATA_WIDTH-1:0]   elem_data;
  logic [2*DATA_WIDTH-1:0] red_vec0;
  logic                    red_en;
  logic [SEW_WIDTH-1:0]    red_sew;
  logic [OPSEL_WIDTH-1:0]  red_opsel;
  logic [DATA_WIDTH-1:0]   red_out;
  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_WIDTH-1:0]   res_data;

  modport slave (
    input  req_valid, req_opsel, req_sew, req_vl, req_init,
    input  elem_valid, elem_data, red_out, res_ready,
    output req_ready, elem_ready, red_vec0, red_en, red_sew, red_opsel,
    output res_valid, res_data
  );

  modport master (
    output req_valid, req_opsel, req_sew, req_vl, req_init,
    output elem_valid, elem_data, red_out, res_ready,
    input  req_ready, elem_ready, red_vec0, red_en, red_sew, red_opsel,
    input  res_valid, res_data
  );
endinterface

// File: rtl/vred_seq_ctrl.sv
// Reduction sequencer: folds vl streamed elements into an accumulator through the pairwise
// reduction datapath and returns the SEW-masked scalar.
//
// state | meaning
// IDLE  | ready for a request
// FETCH | waiting for the next element
// ISSUE | red_en high, datapath samples {element, acc}
// WAIT  | counting down RED_LAT for the datapath result
// DONE  | result held on res_* until accepted
module vred_seq_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 9,
  parameter int SEW_WIDTH   = 2,
  parameter int VL_WIDTH    = 8,
  parameter int RED_LAT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  vred_seq_ctrl_if.slave  bus,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

  localparam int WCNT_W = (RED_LAT < 2) ? 1 : $clog2(RED_LAT + 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [VL_WIDTH-1:0]     cnt_q, cnt_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [OPSEL_WIDTH-1:0]  opsel_q, opsel_d;
  logic [SEW_WIDTH-1:0]    sew_q, sew_d;
  logic [2*DATA_WIDTH-1:0] red_vec0_q, red_vec0_d;
  logic                    red_en_q, red_en_d;
  logic                    req_ready_q, req_ready_d;
  logic                    elem_ready_q, elem_ready_d;
  logic                    res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    busy_q, busy_d;

  // Keeps the low 8<<sew bits; widths beyond DATA_WIDTH simply keep everything.
  function automatic logic [DATA_WIDTH-1:0] sew_mask(input logic [SEW_WIDTH-1:0] sew,
                                                     input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] m;
    int bits;
    bits = 8 << sew;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < bits);
    return v & m;
  endfunction

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    opsel_d      = opsel_q;
    sew_d        = sew_q;
    red_vec0_d   = red_vec0_q;
    red_en_d     = red_en_q;
    req_ready_d  = req_ready_q;
    elem_ready_d = elem_ready_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          opsel_d     = bus.req_opsel;
          sew_d       = bus.req_sew;
          acc_d       = bus.req_init;
          cnt_d       = bus.req_vl;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (bus.req_vl == '0) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = sew_mask(bus.req_sew, bus.req_init);
          end else begin
            state_d      = FETCH;
            elem_ready_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (bus.elem_valid) begin
          red_vec0_d   = {bus.elem_data, acc_q};
          elem_ready_d = 1'b0;
          red_en_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        red_en_d = 1'b0;
        wcnt_d   = WCNT_W'(RED_LAT);
        state_d  = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WCNT_W'(1)) begin
          acc_d = bus.red_out;
          cnt_d = cnt_q - VL_WIDTH'(1);
          if (cnt_q == VL_WIDTH'(1)) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = sew_mask(sew_q, bus.red_out);
          end else begin
            state_d      = FETCH;
            elem_ready_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        red_en_d     = 1'b0;
        elem_ready_d = 1'b0;
        res_valid_d  = 1'b0;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      opsel_q      <= '0;
      sew_q        <= '0;
      red_vec0_q   <= '0;
      red_en_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      elem_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      opsel_q      <= opsel_d;
      sew_q        <= sew_d;
      red_vec0_q   <= red_vec0_d;
      red_en_q     <= red_en_d;
      req_ready_q  <= req_ready_d;
      elem_ready_q <= elem_ready_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.elem_ready = elem_ready_q;
  assign bus.red_vec0   = red_vec0_q;
  assign bus.red_en     = red_en_q;
  assign bus.red_sew    = sew_q;
  assign bus.red_opsel  = opsel_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign busy           = busy_q;
endmodule
